// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O port block with synchronized switches, debounced
// sticky button flags, LED/display registers and a free-running timer.
module io_responder #(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  dirport,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        io_ready,
  input  logic [15:0] sw_in,
  input  logic [3:0]  btn_in,
  output logic [15:0] led_out,
  output logic [15:0] seg_out
);
  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES - 1);
  logic [15:0] sw_s1, sw_s2, timer, rd_val;
  logic [3:0]  btn_s1, btn_s2, btn_lvl, btn_flags, btn_done, btn_rise;
  logic [7:0]  cnt [4];
  logic        enable, overflow, rd, wr_timer, wr_tctrl, wrap;
  always_comb begin
    rd = io_rd & ~io_wr;
    wr_timer = io_wr && dirport == 5'h04;
    wr_tctrl = io_wr && dirport == 5'h05;
    // a reload of the timer replaces the increment, so it can never wrap that cycle
    wrap = enable & (&timer) & ~wr_timer;
    btn_done = '0;
    for (int i = 0; i < 4; i++) btn_done[i] = (btn_s2[i] != btn_lvl[i]) && cnt[i] == DEB_MAX;
    btn_rise = btn_done & btn_s2;
    rd_val = dirport == 5'h00 ? sw_s2 :
             dirport == 5'h01 ? {12'h000, btn_flags} :
             dirport == 5'h02 ? led_out :
             dirport == 5'h03 ? seg_out :
             dirport == 5'h04 ? timer :
             dirport == 5'h05 ? {overflow, 14'h0000, enable} : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {sw_s1, sw_s2, btn_s1, btn_s2, btn_lvl, btn_flags} <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
      {rdata, io_ready, led_out, seg_out, timer, enable, overflow} <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      for (int i = 0; i < 4; i++)
        cnt[i] <= (btn_s2[i] != btn_lvl[i] && !btn_done[i]) ? cnt[i] + 8'd1 : 8'd0;
      btn_lvl <= btn_lvl ^ btn_done;
      // set beats clear: a same-cycle rise survives the read
      btn_flags <= ((rd && dirport == 5'h01) ? 4'h0 : btn_flags) | btn_rise;
      io_ready <= io_rd | io_wr;
      if (rd) rdata <= rd_val;
      if (io_wr && dirport == 5'h02) led_out <= wdata;
      if (io_wr && dirport == 5'h03) seg_out <= wdata;
      timer <= wr_timer ? wdata : enable ? timer + 16'd1 : timer;
      if (wr_tctrl) enable <= wdata[0];
      overflow <= wrap | (overflow & ~(wr_tctrl & wdata[15]));
    end
  end
endmodule
